// File: rtl/conv_col_writer_if.sv
// Column-in / memory-out bundle for conv_col_writer.
// master = column producer / memory side, slave = the writer.
interface conv_col_writer_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int IMAGE_SIZE  = 28,
    parameter int KERNEL_SIZE = 5,
    parameter int WORD_WIDTH  = 256,
    parameter int ADDR_WIDTH  = 12
) ();
    localparam int OUT_SIZE = IMAGE_SIZE - KERNEL_SIZE + 1;
    localparam int COL_W    = $clog2(IMAGE_SIZE) + 1;

    logic                  valid_col_in;
    logic [COL_W-1:0]      col_num_in;
    logic [DATA_WIDTH-1:0] col_data_in [OUT_SIZE];
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WORD_WIDTH-1:0] mem_wdata;

    modport master (
        output valid_col_in, col_num_in, col_data_in,
        input  mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  valid_col_in, col_num_in, col_data_in,
        output mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/conv_col_writer.sv
// Layer-0 conv column write-back: 2-entry column FIFO, two words per column.
// CONV_COL_WRITER_RELU_EN: zero sign-set elements at the FIFO push.
module conv_col_writer #(
    parameter int DATA_WIDTH  = 16,
    parameter int IMAGE_SIZE  = 28,
    parameter int KERNEL_SIZE = 5,
    parameter int WORD_WIDTH  = 256,
    parameter int ADDR_WIDTH  = 12,
    parameter int BASE_ADDR   = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    conv_col_writer_if.slave bus,
    output logic busy,
    output logic frame_done,
    output logic overflow
);
    localparam int OUT_SIZE = IMAGE_SIZE - KERNEL_SIZE + 1;
    localparam int COL_W    = $clog2(IMAGE_SIZE) + 1;
    localparam int LANES    = WORD_WIDTH / DATA_WIDTH;
    localparam int CNT_W    = $clog2(OUT_SIZE + 1);

    typedef enum logic [2:0] {IDLE, ARMED, WR_LO, WR_HI, DONE} state_t;
    typedef logic [OUT_SIZE-1:0][DATA_WIDTH-1:0] col_t;

    state_t                state_q, state_d;
    logic [1:0]            cnt_q;
    logic [COL_W-1:0]      col0, col1, hd_col;
    col_t                  dat0, dat1, hd_dat, push_dat;
    logic [CNT_W-1:0]      wr_q;
    logic                  ovf_q;
    logic                  active, in_range, push, drop, pop;
    logic [2*LANES-1:0][DATA_WIDTH-1:0] ext;
    logic [ADDR_WIDTH-1:0] addr_lo;

    assign active   = (state_q == ARMED) || (state_q == WR_LO) ||
                      (state_q == WR_HI);
    assign in_range = bus.col_num_in < COL_W'(OUT_SIZE);
    assign push     = active && bus.valid_col_in && in_range &&
                      (cnt_q != 2'd2);
    assign drop     = active && bus.valid_col_in &&
                      (!in_range || cnt_q == 2'd2);
    assign pop      = (state_q == WR_HI);

    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);
    assign overflow   = ovf_q;

    // Incoming column, optionally rectified before it enters the FIFO
    always_comb begin
        push_dat = '0;
        for (int k = 0; k < OUT_SIZE; k++) begin
            push_dat[k] = bus.col_data_in[k];
`ifdef CONV_COL_WRITER_RELU_EN
            if (push_dat[k][DATA_WIDTH-1]) push_dat[k] = '0;
`endif
        end
    end

    // Column to be written next: the second entry when leaving WR_HI
    always_comb begin
        hd_col = col0;
        hd_dat = dat0;
        if (state_q == WR_HI) begin
            hd_col = col1;
            hd_dat = dat1;
        end
        ext = '0;
        for (int k = 0; k < OUT_SIZE; k++) ext[k] = hd_dat[k];
        addr_lo = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'({hd_col, 1'b0});
    end

    // Two-entry FIFO; a pop shifts entry 1 forward
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            col0  <= '0;
            col1  <= '0;
            dat0  <= '0;
            dat1  <= '0;
        end else if (state_q == IDLE) begin
            cnt_q <= '0;
        end else begin
            if (pop) begin
                col0 <= col1;
                dat0 <= dat1;
            end
            if (push) begin
                if (cnt_q == 2'd0 || (pop && cnt_q == 2'd1)) begin
                    col0 <= bus.col_num_in;
                    dat0 <= push_dat;
                end else begin
                    col1 <= bus.col_num_in;
                    dat1 <= push_dat;
                end
            end
            cnt_q <= cnt_q + 2'(push) - 2'(pop);
        end
    end

    // Written-column count and sticky drop flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            ovf_q <= 1'b0;
        end else if (state_q == IDLE) begin
            wr_q <= '0;
            if (start) ovf_q <= 1'b0;
        end else begin
            if (pop)  wr_q  <= wr_q + 1'b1;
            if (drop) ovf_q <= 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = ARMED;
            ARMED: begin
                if (cnt_q != 2'd0)                 state_d = WR_LO;
                else if (wr_q == CNT_W'(OUT_SIZE)) state_d = DONE;
            end
            WR_LO: state_d = WR_HI;
            WR_HI: begin
                if (cnt_q == 2'd2)                        state_d = WR_LO;
                else if (wr_q + 1'b1 == CNT_W'(OUT_SIZE)) state_d = DONE;
                else                                      state_d = ARMED;
            end
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered memory port, loaded for the state being entered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            unique case (1'b1)
                (state_d == WR_LO): begin
                    bus.mem_we    <= 1'b1;
                    bus.mem_addr  <= addr_lo;
                    bus.mem_wdata <= ext[LANES-1:0];
                end
                (state_d == WR_HI): begin
                    bus.mem_we    <= 1'b1;
                    bus.mem_addr  <= addr_lo + 1'b1;
                    bus.mem_wdata <= ext[2*LANES-1:LANES];
                end
                default: begin
                    bus.mem_we    <= 1'b0;
                    bus.mem_addr  <= '0;
                    bus.mem_wdata <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conv_col_writer.sv
// Bench for conv_col_writer: write scoreboard plus vector table.
// Build with CONV_COL_WRITER_RELU_EN to check the rectified variant.
module tb_conv_col_writer;
    localparam int DW = 16;
    localparam int OS = 24;
    localparam int CW = 6;
    localparam int WW = 256;
    localparam int AW = 12;

    typedef logic [OS-1:0][DW-1:0] cdata_t;
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } wr_t;
    typedef struct {
        int          col;
        logic [15:0] val;
        bit          acc;
        bit          ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, frame_done, overflow;

    conv_col_writer_if bus ();

    conv_col_writer dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .bus(bus.slave),
        .busy(busy),
        .frame_done(frame_done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    wr_t  sbq[$];
    wr_t  exp_w;
    vec_t tbl[6];
    int   nvec = 0;
    int   nerr = 0;
    int   nwr = 0;
    int   ndone = 0;

    task automatic check(string n, logic [WW-1:0] act, logic [WW-1:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %h want %h", n, act, req);
        end
    endtask

    function automatic cdata_t relu(cdata_t d);
        cdata_t r = d;
`ifdef CONV_COL_WRITER_RELU_EN
        for (int i = 0; i < OS; i++) if (r[i][15]) r[i] = 16'h0000;
`endif
        return r;
    endfunction

    function automatic cdata_t pat(int c);
        cdata_t d;
        for (int r = 0; r < OS; r++) d[r] = {c[7:0], r[7:0]};
        return d;
    endfunction

    function automatic cdata_t fillv(logic [15:0] v);
        cdata_t d;
        for (int r = 0; r < OS; r++) d[r] = v + 16'(r);
        return d;
    endfunction

    task automatic push_exp(int c, cdata_t d);
        cdata_t e = relu(d);
        wr_t w;
        w.addr = AW'(2 * c);
        w.data = e[15:0];
        sbq.push_back(w);
        w.addr = AW'(2 * c + 1);
        w.data = {128'h0, e[23:16]};
        sbq.push_back(w);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(int c, cdata_t d, bit acc);
        bus.valid_col_in = 1'b1;
        bus.col_num_in = CW'(c);
        for (int r = 0; r < OS; r++) bus.col_data_in[r] = d[r];
        if (acc) push_exp(c, d);
    endtask

    task automatic wait_done(string n);
        int d0 = ndone;
        for (int i = 0; i < 100 && ndone == d0; i++) tick();
        repeat (3) tick();
        check({n, "_done_pulses"}, WW'(ndone - d0), 1);
        check({n, "_sb_empty"}, WW'(sbq.size()), 0);
    endtask

    task automatic check_reset_outs(string n);
        check({n, "_we"}, bus.mem_we, 0);
        check({n, "_addr"}, bus.mem_addr, 0);
        check({n, "_wdata"}, bus.mem_wdata, 0);
        check({n, "_busy"}, busy, 0);
        check({n, "_done"}, frame_done, 0);
        check({n, "_ovf"}, overflow, 0);
    endtask

    // Write monitor: every write must match the scoreboard head
    always @(negedge clk) begin
        if (rst && bus.mem_we) begin
            nwr++;
            if (sbq.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_write: addr %0d",
                         bus.mem_addr);
            end else begin
                exp_w = sbq.pop_front();
                check("wr_addr", bus.mem_addr, exp_w.addr);
                check("wr_data", bus.mem_wdata, exp_w.data);
            end
        end
        if (rst && frame_done) ndone++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        int  w0, d0;
        bit  found;

        tbl[0] = '{0,  16'hB000, 1'b1, 1'b0};
        tbl[1] = '{1,  16'h3400, 1'b1, 1'b0};
        tbl[2] = '{24, 16'h1111, 1'b0, 1'b1};
        tbl[3] = '{2,  16'h8000, 1'b1, 1'b1};
        tbl[4] = '{31, 16'h2222, 1'b0, 1'b1};
        tbl[5] = '{3,  16'h7C00, 1'b1, 1'b1};

        bus.valid_col_in = 1'b0;
        bus.col_num_in = '0;
        for (int r = 0; r < OS; r++) bus.col_data_in[r] = '0;

        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("reset");
        rst = 1'b1;
        tick();

        // Columns in IDLE are ignored
        w0 = nwr;
        put(3, pat(3), 0);
        tick();
        put(7, pat(7), 0);
        tick();
        bus.valid_col_in = 1'b0;
        repeat (4) tick();
        check("idle_ignore_writes", WW'(nwr - w0), 0);
        check("idle_busy", busy, 0);

        // Sequential frame, with a stray start mid-frame
        w0 = nwr;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("seq_busy", busy, 1);
        for (int c = 0; c < OS; c++) begin
            put(c, pat(c), 1);
            if (c == 10) start = 1'b1;
            tick();
            bus.valid_col_in = 1'b0;
            start = 1'b0;
            tick();
        end
        wait_done("seq");
        check("seq_writes", WW'(nwr - w0), 48);
        check("seq_ovf", overflow, 0);
        check("seq_idle", busy, 0);

        // Table frame: data values, range drops, sticky overflow
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            put(tbl[i].col, fillv(tbl[i].val), tbl[i].acc);
            tick();
            bus.valid_col_in = 1'b0;
            tick();
            check($sformatf("tbl%0d_ovf", i), overflow, WW'(tbl[i].ovf));
        end
        d0 = ndone;
        for (int c = 4; c < OS; c++) begin
            if (c == OS - 1) begin
                check("tbl_not_done_early", WW'(ndone - d0), 0);
                check("tbl_busy_before_last", busy, 1);
            end
            put(c, pat(c), 1);
            tick();
            bus.valid_col_in = 1'b0;
            tick();
        end
        wait_done("tbl");

        // Burst: third back-to-back column finds the FIFO full
        start = 1'b1;
        tick();
        start = 1'b0;
        check("burst_ovf_cleared", overflow, 0);
        put(0, pat(0), 1);
        tick();
        put(1, pat(1), 1);
        tick();
        put(2, pat(2), 0);
        tick();
        bus.valid_col_in = 1'b0;
        repeat (4) tick();
        check("burst_ovf", overflow, 1);
        for (int c = 2; c < OS; c++) begin
            if (c == 20) check("burst_ovf_sticky", overflow, 1);
            put(c, pat(c), 1);
            tick();
            bus.valid_col_in = 1'b0;
            tick();
        end
        wait_done("burst");

        // Reset during WR_LO of column 5
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rst_ovf_after_start", overflow, 0);
        for (int c = 0; c < 6; c++) begin
            put(c, pat(c), 1);
            tick();
            bus.valid_col_in = 1'b0;
            if (c < 5) tick();
        end
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.mem_we && bus.mem_addr == AW'(10)) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("rst_found_wr_lo_col5", found, 1);
        rst = 1'b0;
        sbq.delete();
        #1;
        check_reset_outs("midrst");
        tick();
        tick();
        rst = 1'b1;
        w0 = nwr;
        for (int c = 0; c < 4; c++) begin
            put(c, pat(c), 0);
            tick();
        end
        bus.valid_col_in = 1'b0;
        repeat (4) tick();
        check("post_rst_no_writes", WW'(nwr - w0), 0);
        check("post_rst_busy", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("post_rst_fifo_empty", WW'(nwr - w0), 0);
        check("post_rst_armed", busy, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
